uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised successor to the single-byte UART transmitter used on the logic probe console path. It adds a configurable frame format (data width, parity, stop bits) and an internal transmit FIFO, so that firmware can queue several characters without polling `busy` per byte. It sits between the CPU peripheral bus and the `tx` pin.

## Interface

Parameters:

- `CLOCK_DIV`, 8: clk cycles per bit period; must be ≥ 2.
- `CLOCK_COUNTER_BITS`, 4: width of the bit-period counter; must satisfy 2^CLOCK_COUNTER_BITS ≥ CLOCK_DIV.
- `DATA_BITS`, 8: data bits per frame; valid range 5..9.
- `PARITY`, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.
- `FIFO_DEPTH_BITS`, 2: FIFO depth is 2^FIFO_DEPTH_BITS entries.

Ports:

- `clk`, input, 1: clock; all logic on the rising edge.
- `nreset`, input, 1: reset, asynchronous, active-low.
- `data`, input, DATA_BITS: character to enqueue.
- `send`, input, 1: enqueue request; acts on its rising edge.
- `tx`, output, 1: serial line; idles high.
- `busy`, output, 1: high while the FIFO is non-empty or a frame is in progress.
- `full`, output, 1: FIFO holds 2^FIFO_DEPTH_BITS entries.
- `level`, output, FIFO_DEPTH_BITS+1: number of entries currently in the FIFO, excluding the frame in the shifter.

## Operation

- **Push**
  - `send` is registered into `send_d`, which resets to 0.
  - A push occurs on any clk edge where `send=1`, `send_d=0` and `full=0`. `data` is written at that edge.
  - Holding `send` high for several cycles enqueues exactly one entry.
  - A rising edge of `send` while `full=1` is dropped silently. It is not retried later.
- **FIFO**
  - Circular buffer with read pointer, write pointer and occupancy count.
  - Pointers wrap modulo 2^FIFO_DEPTH_BITS.
  - `full` and `level` come from registered state. A pop on the same edge does not free space for a push on that edge.
- **Transmit FSM** states:
  - **IDLE**: `tx=1`. If the FIFO is non-empty, pop the head into the shifter, clear the bit counter and go to START.
  - **START**: `tx=0` for CLOCK_DIV cycles, then go to DATA.
  - **DATA**: shift out DATA_BITS bits, LSB first, CLOCK_DIV cycles each. Then go to PARITY if PARITY≠0, otherwise to STOP.
  - **PARITY**: `tx` = XOR of the data bits for even parity, or its complement for odd parity. Lasts CLOCK_DIV cycles, then go to STOP.
  - **STOP**: `tx=1` for STOP_BITS×CLOCK_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle cycle. Otherwise go to IDLE.
- Parity is computed from the value latched in the shifter at pop time. Later changes to `data` have no effect on it.
- **Reset** (asynchronous, including mid-frame):
  - `tx=1`, `busy=0`, `full=0`, `level=0`.
  - FSM goes to IDLE; pointers, counters and `send_d` are cleared.
  - Any partial frame is truncated.

## Timing

- A push at edge E0 makes `level` increment after E0.
- The IDLE→START pop occurs at E1, the next edge. `tx` falls after E1, so latency from the push edge to the start bit is 1 cycle.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLOCK_DIV cycles.
- Back-to-back frames: the start bit of frame n+1 begins on the edge that ends the last stop bit of frame n.
- `busy` rises after E0, in the same cycle `level` becomes 1. It falls after the edge that ends the final stop bit with the FIFO empty.
- `full` and `level` update one edge after a push or pop. A simultaneous push and pop leaves `level` unchanged.
- Maximum queued characters is 2^FIFO_DEPTH_BITS in the FIFO plus 1 in the shifter.

## Test plan

Defaults unless stated: CLOCK_DIV=8.

1. Reset, then push 0x5A (8N1).
   - `tx` per bit period: 0, 0,1,0,1,1,0,1,0, 1.
   - Frame is 80 cycles; `busy` is high throughout and low afterwards; `level` returns to 0.
2. PARITY=2, push 0xA5.
   - Parity bit is 0.
   - Rebuild with PARITY=1: parity bit is 1.
   - Frame is 88 cycles.
3. STOP_BITS=2, DATA_BITS=7, push 0x41 then 0x42 back-to-back.
   - Two frames of 80 cycles each with no idle gap.
   - Second start bit begins exactly 80 cycles after the first.
4. FIFO_DEPTH_BITS=2: issue 6 `send` rising edges, 2 cycles apart, with data 1..6.
   - Byte 1 is in the shifter; bytes 2..5 are in the FIFO.
   - `full=1`, `level=4`; byte 6 is dropped.
   - Line shows exactly 5 frames, carrying 1..5 in order.
5. Hold `send` high for 20 cycles with 0x33.
   - Exactly one frame is transmitted.
6. Assert `nreset` low mid-data-bit of a queued burst.
   - `tx=1`, `busy=0`, `level=0` immediately, without waiting for clk.
   - After release, a new push of 0x5A transmits cleanly, per scenario 1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Purpose : UART transmitter with a small transmit FIFO and configurable frame
//           (5..9 data bits, none/odd/even parity, 1 or 2 stop bits).
// Latency : push at edge E0 -> start bit on tx after E0+1; frame is
//           (1 + DATA_BITS + parity + STOP_BITS) * CLOCK_DIV cycles.
// Backpr. : no stall; a send rising edge while full is dropped, never retried.
//
// Ports (uart_tx_fifo):
//   clk    - clock, rising edge
//   nreset - asynchronous active-low reset
//   data   - character to enqueue (DATA_BITS)
//   send   - enqueue request, acts on its rising edge
//   tx     - serial line, idles high
//   busy   - FIFO non-empty or frame in progress
//   full   - FIFO holds 2^FIFO_DEPTH_BITS entries
//   level  - FIFO occupancy, excluding the frame in the shifter

// Purpose : circular-buffer FIFO with read/write pointers and occupancy count.
// Latency : push visible on pop_dat/level one edge after the push edge.
// Backpr. : push ignored when full, pop ignored when empty; full/level registered.
module uart_tx_fifo_buf #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Both qualifiers use the registered count, so a pop on the same edge
    // never makes room for a push on that edge.
    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign level   = count;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// Purpose : top level, send edge detect + FIFO + serialising frame FSM.
// Latency : 1 cycle from push edge to start bit; back-to-back frames gapless.
// Backpr. : none toward the bus; overflow pushes are silently dropped.
module uart_tx_fifo #(
    parameter int CLOCK_DIV          = 8,
    parameter int CLOCK_COUNTER_BITS = 4,
    parameter int DATA_BITS          = 8,
    parameter int PARITY             = 0,
    parameter int STOP_BITS          = 1,
    parameter int FIFO_DEPTH_BITS    = 2
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic [DATA_BITS-1:0]       data,
    input  logic                       send,
    output logic                       tx,
    output logic                       busy,
    output logic                       full,
    output logic [FIFO_DEPTH_BITS:0]   level
);
    localparam logic [CLOCK_COUNTER_BITS-1:0] DIV_LAST = CLOCK_COUNTER_BITS'(CLOCK_DIV - 1);
    localparam logic [CLOCK_COUNTER_BITS-1:0] CLK_ONE  = CLOCK_COUNTER_BITS'(1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [3:0] BIT_ONE   = 4'd1;
    localparam logic       ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                          state, state_n;
    logic [CLOCK_COUNTER_BITS-1:0]   clk_cnt, clk_cnt_n;
    logic [3:0]                      bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0]            shifter, shifter_n;
    logic                            par_bit, par_bit_n;
    logic                            tx_n;
    logic                            send_d;
    logic                            push;
    logic                            pop;
    logic [DATA_BITS-1:0]            head_dat;
    logic                            fifo_empty;
    logic                            bit_end;

    // Rising-edge detect: holding send high enqueues exactly one entry.
    assign push = send && !send_d;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            send_d <= 1'b0;
        end else begin
            send_d <= send;
        end
    end

    uart_tx_fifo_buf #(
        .W  (DATA_BITS),
        .AW (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk      (clk),
        .nreset   (nreset),
        .push     (push),
        .push_dat (data),
        .pop      (pop),
        .pop_dat  (head_dat),
        .full     (full),
        .empty    (fifo_empty),
        .level    (level)
    );

    assign bit_end = (clk_cnt == DIV_LAST);
    assign busy    = !fifo_empty || (state != S_IDLE);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shifter <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_cnt <= bit_cnt_n;
            shifter <= shifter_n;
            par_bit <= par_bit_n;
            tx      <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_cnt_n = bit_cnt;
        shifter_n = shifter;
        par_bit_n = par_bit;
        pop       = 1'b0;

        case (state)
            S_IDLE: begin
                clk_cnt_n = '0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shifter_n = head_dat;
                    // Parity is fixed from the popped value, not the live data input.
                    par_bit_n = (^head_dat) ^ ODD;
                    bit_cnt_n = '0;
                    state_n   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    state_n   = S_DATA;
                end else begin
                    clk_cnt_n = clk_cnt + CLK_ONE;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    shifter_n = shifter >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_ONE;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CLK_ONE;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    state_n   = S_STOP;
                end else begin
                    clk_cnt_n = clk_cnt + CLK_ONE;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt_n = '0;
                        // Gapless chaining: the next start bit begins on the
                        // edge that ends this stop bit.
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            shifter_n = head_dat;
                            par_bit_n = (^head_dat) ^ ODD;
                            state_n   = S_START;
                        end else begin
                            state_n   = S_IDLE;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_ONE;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CLK_ONE;
                end
            end
            default: begin
                state_n   = S_IDLE;
                clk_cnt_n = '0;
                bit_cnt_n = '0;
            end
        endcase
    end

    // tx is registered from the next-state values so the pin is glitch-free
    // yet still changes on the same edge as the FSM.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shifter_n[0];
            S_PARITY: tx_n = par_bit_n;
            default:  tx_n = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Purpose : directed bench for uart_tx_fifo across four frame formats.
// Latency : frames sampled mid-bit, exact frame boundaries checked per cycle.
// Backpr. : exercises FIFO overflow drop and held send.
module tb_uart_tx_fifo;
    localparam int DIV = 8;

    logic       clk    = 1'b0;
    logic       nreset = 1'b0;
    logic       send  [4];
    logic [7:0] data  [4];
    logic       tx    [4];
    logic       busy  [4];
    logic       full  [4];
    logic [2:0] level [4];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2
    uart_tx_fifo u_8n1 (
        .clk(clk), .nreset(nreset), .data(data[0]), .send(send[0]),
        .tx(tx[0]), .busy(busy[0]), .full(full[0]), .level(level[0])
    );
    uart_tx_fifo #(.PARITY(2)) u_8e1 (
        .clk(clk), .nreset(nreset), .data(data[1]), .send(send[1]),
        .tx(tx[1]), .busy(busy[1]), .full(full[1]), .level(level[1])
    );
    uart_tx_fifo #(.PARITY(1)) u_8o1 (
        .clk(clk), .nreset(nreset), .data(data[2]), .send(send[2]),
        .tx(tx[2]), .busy(busy[2]), .full(full[2]), .level(level[2])
    );
    uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .nreset(nreset), .data(data[3][6:0]), .send(send[3]),
        .tx(tx[3]), .busy(busy[3]), .full(full[3]), .level(level[3])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] val);
        data[idx] = val;
        send[idx] = 1'b1;
        tick();
        send[idx] = 1'b0;
    endtask

    // Entered 'off' cycles after the edge on which the start bit began.
    // bits[k] is the k-th bit on the line (start first).
    task automatic check_frame(input int idx, input string tag, input logic [15:0] bits,
                               input int nbits, input bit more, input int off);
        int pos;
        pos = off;
        for (int k = 0; k < nbits; k++) begin
            int target;
            target = k * DIV + DIV / 2;
            if (target >= pos) begin
                repeat (target - pos) tick();
                pos = target;
                chk($sformatf("%s bit%0d tx", tag, k), 16'(tx[idx]), 16'(bits[k]));
                chk($sformatf("%s bit%0d busy", tag, k), 16'(busy[idx]), 16'h1);
            end
        end
        repeat (nbits * DIV - 1 - pos) tick();
        chk({tag, " last cycle tx"}, 16'(tx[idx]), 16'h1);
        chk({tag, " last cycle busy"}, 16'(busy[idx]), 16'h1);
        tick();
        if (more) begin
            chk({tag, " next start tx"}, 16'(tx[idx]), 16'h0);
            chk({tag, " next start busy"}, 16'(busy[idx]), 16'h1);
        end else begin
            chk({tag, " end tx"}, 16'(tx[idx]), 16'h1);
            chk({tag, " end busy"}, 16'(busy[idx]), 16'h0);
            chk({tag, " end level"}, 16'(level[idx]), 16'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            send[i] = 1'b0;
            data[i] = 8'h00;
        end

        // Reset state
        nreset = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset tx%0d", i), 16'(tx[i]), 16'h1);
            chk($sformatf("reset busy%0d", i), 16'(busy[i]), 16'h0);
            chk($sformatf("reset full%0d", i), 16'(full[i]), 16'h0);
            chk($sformatf("reset level%0d", i), 16'(level[i]), 16'h0);
        end
        nreset = 1'b1;
        tick();

        // 1: 8N1 0x5A
        push(0, 8'h5A);
        chk("s1 level after push", 16'(level[0]), 16'h1);
        chk("s1 busy after push", 16'(busy[0]), 16'h1);
        chk("s1 tx before start", 16'(tx[0]), 16'h1);
        tick();
        chk("s1 start tx", 16'(tx[0]), 16'h0);
        chk("s1 level after pop", 16'(level[0]), 16'h0);
        check_frame(0, "s1", 16'({1'b1, 8'h5A, 1'b0}), 10, 1'b0, 0);
        repeat (5) tick();
        chk("s1 idle tx", 16'(tx[0]), 16'h1);

        // 2: 0xA5 even parity (0) and odd parity (1), 88 cycles
        push(1, 8'hA5);
        tick();
        check_frame(1, "s2 even", 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 1'b0, 0);
        push(2, 8'hA5);
        tick();
        check_frame(2, "s2 odd", 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, 1'b0, 0);

        // 3: 7N2 back-to-back 0x41, 0x42
        push(3, 8'h41);
        tick();
        data[3] = 8'h42;
        send[3] = 1'b1;
        tick();
        send[3] = 1'b0;
        chk("s3 level queued", 16'(level[3]), 16'h1);
        check_frame(3, "s3 f1", 16'({2'b11, 7'h41, 1'b0}), 10, 1'b1, 1);
        check_frame(3, "s3 f2", 16'({2'b11, 7'h42, 1'b0}), 10, 1'b0, 0);

        // 4: overflow, 6 sends 2 cycles apart, byte 6 dropped
        for (int i = 1; i <= 6; i++) begin
            data[0] = 8'(i);
            send[0] = 1'b1;
            tick();
            send[0] = 1'b0;
            tick();
        end
        chk("s4 full", 16'(full[0]), 16'h1);
        chk("s4 level", 16'(level[0]), 16'h4);
        check_frame(0, "s4 f1", 16'({1'b1, 8'd1, 1'b0}), 10, 1'b1, 10);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("s4 level at f%0d", i), 16'(level[0]), 16'(5 - i));
            check_frame(0, $sformatf("s4 f%0d", i), 16'({1'b1, 8'(i), 1'b0}), 10, (i < 5), 0);
        end
        repeat (20) tick();
        chk("s4 no sixth frame", 16'(busy[0]), 16'h0);

        // 5: send held high for 20 cycles -> one frame
        data[0] = 8'h33;
        send[0] = 1'b1;
        tick();
        chk("s5 level", 16'(level[0]), 16'h1);
        fork
            begin
                repeat (19) tick();
                send[0] = 1'b0;
            end
            begin
                tick();
                check_frame(0, "s5", 16'({1'b1, 8'h33, 1'b0}), 10, 1'b0, 0);
            end
        join
        repeat (10) tick();
        chk("s5 still idle busy", 16'(busy[0]), 16'h0);
        chk("s5 still idle level", 16'(level[0]), 16'h0);

        // 6: async reset mid-data-bit of a queued burst
        push(0, 8'h00);
        tick();
        push(0, 8'h11);
        tick();
        push(0, 8'h22);
        repeat (17) tick();
        chk("s6 tx mid data", 16'(tx[0]), 16'h0);
        chk("s6 level queued", 16'(level[0]), 16'h2);
        #2;
        nreset = 1'b0;
        #1;
        chk("s6 async tx", 16'(tx[0]), 16'h1);
        chk("s6 async busy", 16'(busy[0]), 16'h0);
        chk("s6 async level", 16'(level[0]), 16'h0);
        chk("s6 async full", 16'(full[0]), 16'h0);
        repeat (2) tick();
        nreset = 1'b1;
        repeat (3) tick();
        chk("s6 idle after release", 16'(tx[0]), 16'h1);
        push(0, 8'h5A);
        chk("s6 level after push", 16'(level[0]), 16'h1);
        tick();
        check_frame(0, "s6", 16'({1'b1, 8'h5A, 1'b0}), 10, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
